regmodel0_mutex0_lock_engine: RTL and testbench

REGMODEL0_MUTEX0_LOCK_ENGINE -- requirements
Module: regmodel0_mutex0_lock_engine

---
 rtl/regmodel0_mutex0_lock_engine.sv | 206 ++++++++++++++++++++
 tb/tb_regmodel0_mutex0_lock_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regmodel0_mutex0_lock_engine.sv
// Hardware mutex with owner/software-ID check, a single recorded waiter,
// a post-release reservation window for that waiter and an optional lease timeout.
module regmodel0_mutex0_lock_engine #(
    parameter int unsigned LEASE_CYCLES = 0,
    parameter int unsigned RES_CYCLES   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  reqinfo,
    input  logic [30:0] swid_din,
    input  logic        swid_w,
    input  logic        swid_r,
    input  logic        lock_din,
    input  logic        lock_w,
    output logic [30:0] swid_qout,
    output logic        lock_qout,
    output logic [5:0]  owner_qout,
    output logic        waiter_vld,
    output logic        acq_ok,
    output logic        acq_fail,
    output logic        rel_pulse,
    output logic        tmo_pulse,
    output logic [7:0]  fail_cnt
);

    typedef enum logic [1:0] {
        S_FREE     = 2'd0,
        S_LOCKED   = 2'd1,
        S_RESERVED = 2'd2
    } state_t;

    localparam logic        LEASE_EN   = (LEASE_CYCLES != 0);
    localparam logic [23:0] LEASE_LAST = 24'(LEASE_CYCLES) - 24'd1;
    localparam logic [7:0]  RES_LOAD   = 8'(RES_CYCLES);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state_q, state_d;
    logic [30:0] swid_q, swid_d;
    logic [5:0]  owner_q, owner_d;
    logic [5:0]  waiter_q, waiter_d;
    logic        wv_q, wv_d;
    logic [23:0] lease_q, lease_d;
    logic [7:0]  res_q, res_d;
    logic [7:0]  fail_cnt_q, fail_cnt_d;
    logic        lock_q, lock_d;
    logic        acq_ok_q, acq_ok_d;
    logic        acq_fail_q, acq_fail_d;
    logic        rel_q, rel_d;
    logic        tmo_q, tmo_d;

    logic acquire_s;
    logic release_s;
    logic owner_match_s;
    logic lease_exp_s;
    logic unused_s;

    assign acquire_s     = lock_w & lock_din;
    assign release_s     = lock_w & ~lock_din;
    assign owner_match_s = (reqinfo == owner_q) && (swid_din == swid_q);
    assign lease_exp_s   = LEASE_EN && (lease_q == LEASE_LAST);
    // Field strobes have no side effect on the lock.
    assign unused_s      = swid_w ^ swid_r;

    // Next-state and event decode, all decisions from pre-edge state.
    always_comb begin
        state_d    = state_q;
        swid_d     = swid_q;
        owner_d    = owner_q;
        waiter_d   = waiter_q;
        wv_d       = wv_q;
        lease_d    = lease_q;
        res_d      = res_q;
        fail_cnt_d = fail_cnt_q;
        acq_ok_d   = 1'b0;
        acq_fail_d = 1'b0;
        rel_d      = 1'b0;
        tmo_d      = 1'b0;

        case (state_q)
            S_FREE: begin
                if (acquire_s) begin
                    state_d  = S_LOCKED;
                    swid_d   = swid_din;
                    owner_d  = reqinfo;
                    lease_d  = 24'd0;
                    acq_ok_d = 1'b1;
                end else begin
                    state_d = S_FREE;
                end
            end
            S_LOCKED: begin
                if ((release_s && owner_match_s) || lease_exp_s) begin
                    // Owner release beats a simultaneous lease expiry.
                    rel_d   = release_s && owner_match_s;
                    tmo_d   = !(release_s && owner_match_s);
                    state_d = wv_q ? S_RESERVED : S_FREE;
                    swid_d  = 31'd0;
                    owner_d = 6'd0;
                    lease_d = 24'd0;
                    res_d   = RES_LOAD;
                    if (acquire_s) begin
                        acq_fail_d = 1'b1;
                        fail_cnt_d = sat_inc(fail_cnt_q);
                    end else begin
                        acq_fail_d = 1'b0;
                    end
                end else begin
                    lease_d = LEASE_EN ? (lease_q + 24'd1) : 24'd0;
                    if (acquire_s) begin
                        acq_fail_d = 1'b1;
                        fail_cnt_d = sat_inc(fail_cnt_q);
                        if (!wv_q) begin
                            waiter_d = reqinfo;
                            wv_d     = 1'b1;
                        end else begin
                            waiter_d = waiter_q;
                        end
                    end else begin
                        acq_fail_d = 1'b0;
                    end
                end
            end
            S_RESERVED: begin
                if (acquire_s && (reqinfo == waiter_q)) begin
                    state_d  = S_LOCKED;
                    swid_d   = swid_din;
                    owner_d  = reqinfo;
                    lease_d  = 24'd0;
                    wv_d     = 1'b0;
                    res_d    = 8'd0;
                    acq_ok_d = 1'b1;
                end else begin
                    if (acquire_s) begin
                        acq_fail_d = 1'b1;
                        fail_cnt_d = sat_inc(fail_cnt_q);
                    end else begin
                        acq_fail_d = 1'b0;
                    end
                    // Window closes after the last reserved cycle.
                    if (res_q <= 8'd1) begin
                        state_d = S_FREE;
                        wv_d    = 1'b0;
                        res_d   = 8'd0;
                    end else begin
                        res_d = res_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_FREE;
                swid_d  = 31'd0;
                owner_d = 6'd0;
                wv_d    = 1'b0;
            end
        endcase

        lock_d = (state_d == S_LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FREE;
            swid_q     <= 31'd0;
            owner_q    <= 6'd0;
            waiter_q   <= 6'd0;
            wv_q       <= 1'b0;
            lease_q    <= 24'd0;
            res_q      <= 8'd0;
            fail_cnt_q <= 8'd0;
            lock_q     <= 1'b0;
            acq_ok_q   <= 1'b0;
            acq_fail_q <= 1'b0;
            rel_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            swid_q     <= swid_d;
            owner_q    <= owner_d;
            waiter_q   <= waiter_d;
            wv_q       <= wv_d;
            lease_q    <= lease_d;
            res_q      <= res_d;
            fail_cnt_q <= fail_cnt_d;
            lock_q     <= lock_d;
            acq_ok_q   <= acq_ok_d;
            acq_fail_q <= acq_fail_d;
            rel_q      <= rel_d;
            tmo_q      <= tmo_d;
        end
    end

    assign swid_qout  = swid_q;
    assign lock_qout  = lock_q;
    assign owner_qout = owner_q;
    assign waiter_vld = wv_q;
    assign acq_ok     = acq_ok_q;
    assign acq_fail   = acq_fail_q;
    assign rel_pulse  = rel_q;
    assign tmo_pulse  = tmo_q;
    assign fail_cnt   = fail_cnt_q;

endmodule

// File: tb/tb_regmodel0_mutex0_lock_engine.sv
// Scoreboard bench: two lock engines (no lease / 8-cycle lease) driven with
// directed operations; hand-computed expectations are queued and a monitor checks them.
module tb_regmodel0_mutex0_lock_engine;

    logic        clk;
    logic        rst_s;
    logic [5:0]  reqinfo_s;
    logic [30:0] swid_din_s;
    logic        swid_w_s;
    logic        swid_r_s;
    logic        lock_din_s;
    logic [1:0]  lock_w_s;

    logic [30:0] swid_o  [2];
    logic        lock_o  [2];
    logic [5:0]  owner_o [2];
    logic        wv_o    [2];
    logic        ok_o    [2];
    logic        fl_o    [2];
    logic        rel_o   [2];
    logic        tmo_o   [2];
    logic [7:0]  fc_o    [2];

    regmodel0_mutex0_lock_engine u_dut0 (
        .clk(clk), .rst(rst_s), .reqinfo(reqinfo_s), .swid_din(swid_din_s),
        .swid_w(swid_w_s), .swid_r(swid_r_s), .lock_din(lock_din_s), .lock_w(lock_w_s[0]),
        .swid_qout(swid_o[0]), .lock_qout(lock_o[0]), .owner_qout(owner_o[0]),
        .waiter_vld(wv_o[0]), .acq_ok(ok_o[0]), .acq_fail(fl_o[0]),
        .rel_pulse(rel_o[0]), .tmo_pulse(tmo_o[0]), .fail_cnt(fc_o[0])
    );

    regmodel0_mutex0_lock_engine #(.LEASE_CYCLES(8), .RES_CYCLES(16)) u_dut1 (
        .clk(clk), .rst(rst_s), .reqinfo(reqinfo_s), .swid_din(swid_din_s),
        .swid_w(swid_w_s), .swid_r(swid_r_s), .lock_din(lock_din_s), .lock_w(lock_w_s[1]),
        .swid_qout(swid_o[1]), .lock_qout(lock_o[1]), .owner_qout(owner_o[1]),
        .waiter_vld(wv_o[1]), .acq_ok(ok_o[1]), .acq_fail(fl_o[1]),
        .rel_pulse(rel_o[1]), .tmo_pulse(tmo_o[1]), .fail_cnt(fc_o[1])
    );

    typedef struct {
        int          due;
        int          d;
        string       name;
        logic [50:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [50:0] actual(input int d);
        actual = {lock_o[d], swid_o[d], owner_o[d], wv_o[d], ok_o[d], fl_o[d],
                  rel_o[d], tmo_o[d], fc_o[d]};
    endfunction

    // Output vector layout: lock,swid,owner,waiter_vld,acq_ok,acq_fail,rel,tmo,fail_cnt
    task automatic expect_out(input int d, input string nm, input logic lk,
                              input logic [30:0] sw, input logic [5:0] ow, input logic wv,
                              input logic ok, input logic fl, input logic rl, input logic tm,
                              input logic [7:0] fc);
        exp_t e;
        e.due  = cyc;
        e.d    = d;
        e.name = nm;
        e.v    = {lk, sw, ow, wv, ok, fl, rl, tm, fc};
        q.push_back(e);
    endtask

    task automatic op(input logic r, input logic [1:0] lw, input logic ld,
                      input logic [5:0] rq, input logic [30:0] sw);
        rst_s      = r;
        lock_w_s   = lw;
        lock_din_s = ld;
        reqinfo_s  = rq;
        swid_din_s = sw;
        swid_w_s   = (lw == 2'b00);
        swid_r_s   = (lw == 2'b00);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        op(1'b0, 2'b00, 1'b0, 6'd0, 31'h5a5a);
    endtask

    // Monitor: pops every expectation due this cycle and compares at the falling edge.
    initial begin
        exp_t        e;
        logic [50:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e   = q.pop_front();
                act = actual(e.d);
                n_chk++;
                if (e.due != cyc)
                    $display("FAIL %s dut%0d: expectation missed (due %0d, now %0d) required %h",
                             e.name, e.d, e.due, cyc, e.v);
                else if (act !== e.v)
                    $display("FAIL %s dut%0d: got %h required %h", e.name, e.d, act, e.v);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        int budget;
        rst_s = 1'b0; lock_w_s = 2'b00; lock_din_s = 1'b0;
        reqinfo_s = 6'd0; swid_din_s = 31'd0; swid_w_s = 1'b0; swid_r_s = 1'b0;
        #2;

        op(1'b1, 2'b00, 1'b0, 6'd0, 31'd0);
        op(1'b1, 2'b00, 1'b0, 6'd0, 31'd0);
        expect_out(0, "reset0", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_out(1, "reset1", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Basic acquire and contention with waiter recording
        op(1'b0, 2'b01, 1'b1, 6'd3, 31'h1234);
        expect_out(0, "acq3", 1'b1, 31'h1234, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        idle();
        expect_out(0, "acq_ok_one_cycle", 1'b1, 31'h1234, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        op(1'b0, 2'b01, 1'b1, 6'd5, 31'h55);
        expect_out(0, "fail5", 1'b1, 31'h1234, 6'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        op(1'b0, 2'b01, 1'b1, 6'd7, 31'h77);
        expect_out(0, "fail7", 1'b1, 31'h1234, 6'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
        op(1'b0, 2'b01, 1'b0, 6'd3, 31'h1234);
        expect_out(0, "rel_to_reserved", 1'b0, 31'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
        op(1'b0, 2'b01, 1'b1, 6'd7, 31'h77);
        expect_out(0, "reserved_fail7", 1'b0, 31'd0, 6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        op(1'b0, 2'b01, 1'b1, 6'd5, 31'h0abc);
        expect_out(0, "waiter5_acq", 1'b1, 31'h0abc, 6'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        op(1'b0, 2'b01, 1'b0, 6'd5, 31'h0abc);
        expect_out(0, "rel5_free", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);

        // Release mismatches are ignored; release in FREE is ignored
        op(1'b0, 2'b01, 1'b1, 6'd3, 31'h1234);
        expect_out(0, "reacq3", 1'b1, 31'h1234, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        op(1'b0, 2'b01, 1'b0, 6'd3, 31'h1235);
        expect_out(0, "rel_bad_swid", 1'b1, 31'h1234, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        op(1'b0, 2'b01, 1'b0, 6'd4, 31'h1234);
        expect_out(0, "rel_bad_owner", 1'b1, 31'h1234, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
        op(1'b0, 2'b01, 1'b0, 6'd3, 31'h1234);
        expect_out(0, "rel_good", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
        op(1'b0, 2'b01, 1'b0, 6'd3, 31'h1234);
        expect_out(0, "rel_in_free", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);

        // Reservation window expiry with an acquire on its last cycle
        op(1'b0, 2'b01, 1'b1, 6'd3, 31'h1234);
        expect_out(0, "acq3_b", 1'b1, 31'h1234, 6'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        op(1'b0, 2'b01, 1'b1, 6'd9, 31'd0);
        expect_out(0, "fail9", 1'b1, 31'h1234, 6'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
        op(1'b0, 2'b01, 1'b0, 6'd3, 31'h1234);
        expect_out(0, "rel_res_b", 1'b0, 31'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        op(1'b0, 2'b01, 1'b0, 6'd3, 31'h1234);
        expect_out(0, "rel_in_reserved", 1'b0, 31'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
        repeat (14) idle();
        expect_out(0, "res_still_open", 1'b0, 31'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
        op(1'b0, 2'b01, 1'b1, 6'd12, 31'h1);
        expect_out(0, "last_res_cycle_fail", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
        op(1'b0, 2'b01, 1'b1, 6'd12, 31'h7fffffff);
        expect_out(0, "free_any_acq", 1'b1, 31'h7fffffff, 6'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);

        // fail_cnt saturation
        for (int i = 1; i <= 260; i++) begin
            op(1'b0, 2'b01, 1'b1, 6'd20, 31'h20);
            if (i == 1 || i == 249 || i == 250 || i == 260)
                expect_out(0, "fail_sat", 1'b1, 31'h7fffffff, 6'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                           (5 + i > 255) ? 8'd255 : 8'(5 + i));
        end

        // Lease timeout on the 8-cycle-lease instance
        op(1'b0, 2'b10, 1'b1, 6'd2, 31'h22);
        expect_out(1, "lease_acq", 1'b1, 31'h22, 6'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        repeat (7) idle();
        expect_out(1, "lease_not_yet", 1'b1, 31'h22, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        idle();
        expect_out(1, "lease_tmo", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        idle();
        expect_out(1, "tmo_one_cycle", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        op(1'b0, 2'b10, 1'b1, 6'd2, 31'h22);
        repeat (7) idle();
        op(1'b0, 2'b10, 1'b0, 6'd2, 31'h22);
        expect_out(1, "rel_wins_expiry", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        op(1'b0, 2'b10, 1'b1, 6'd2, 31'h22);
        op(1'b0, 2'b10, 1'b1, 6'd6, 31'h66);
        expect_out(1, "lease_fail6", 1'b1, 31'h22, 6'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        repeat (6) idle();
        idle();
        expect_out(1, "tmo_to_reserved", 1'b0, 31'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        op(1'b0, 2'b10, 1'b1, 6'd6, 31'h66);
        expect_out(1, "waiter6_acq", 1'b1, 31'h66, 6'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);

        // Reset overrides a same-cycle acquire and abandons held locks silently
        op(1'b1, 2'b11, 1'b1, 6'd1, 31'h11);
        expect_out(0, "rst_over_acq0", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_out(1, "rst_over_acq1", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        idle();
        expect_out(0, "post_rst0", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        expect_out(1, "post_rst1", 1'b0, 31'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            idle();
            budget--;
        end
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            $display("FAIL %s dut%0d: never compared, required %h", e.name, e.d, e.v);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
